// File: rtl/serial_and16.sv
// Serial 16-bit AND: one bit per cycle, LSB first, through a 1-bit datapath, with valid/ready handshakes.
// Optional macro SERIAL_AND16_NAND_EN adds a nand_sel input, sampled at accept, that inverts every result bit.
module serial_and16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        busy
`ifdef SERIAL_AND16_NAND_EN
  ,
  input  logic        nand_sel
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] res_q, res_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        bit_res;

`ifdef SERIAL_AND16_NAND_EN
  logic        nand_q, nand_d;

  assign bit_res = (a_q[0] & b_q[0]) ^ nand_q;
`else
  assign bit_res = a_q[0] & b_q[0];
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_AND16_NAND_EN
    nand_d  = nand_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          res_d   = 16'h0000;
          cnt_d   = 4'd0;
`ifdef SERIAL_AND16_NAND_EN
          nand_d  = nand_sel;
`endif
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // The newest bit enters at the MSB, so after 16 shifts bit 0 has reached position 0.
        a_d   = {1'b0, a_q[15:1]};
        b_d   = {1'b0, b_q[15:1]};
        res_d = {bit_res, res_q[15:1]};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd15) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_q   <= 16'h0000;
      cnt_q   <= 4'd0;
`ifdef SERIAL_AND16_NAND_EN
      nand_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_AND16_NAND_EN
      nand_q  <= nand_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == SHIFT);
  assign out_valid = (state_q == DONE);
  assign out       = res_q;

endmodule

// File: doc/serial_and16.md
SERIAL_AND16 -- requirements
Module: serial_and16

Interface
REQ-001 The module SHALL have no parameters; the data width SHALL be fixed at 16 bits.
REQ-002 clock  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair on a/b is offered.
REQ-005 in_ready  output  1  block accepts an operand pair this cycle.
REQ-006 a  input  16  first operand, sampled at accept.
REQ-007 b  input  16  second operand, sampled at accept.
REQ-008 out_valid  output  1  result on out is valid.
REQ-009 out_ready  input  1  consumer takes the result this cycle.
REQ-010 out  output  16  result word.
REQ-011 busy  output  1  high while in SHIFT.

Function
REQ-012 The module SHALL compute out[i] = a[i] AND b[i] for i = 0..15, one bit per cycle, LSB first, through a single 1-bit And datapath.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 in_ready SHALL be 1 in IDLE only; out_valid SHALL be 1 in DONE only; busy SHALL be 1 in SHIFT only.
REQ-015 Accept SHALL occur on an edge where in_valid=1 and in_ready=1: a and b SHALL be latched into shift registers, the result register cleared, the 4-bit bit counter set to 0, and the state set to SHIFT.
REQ-016 In SHIFT, each edge SHALL shift the operand registers right by one, shift (a_reg[0] AND b_reg[0]) into result bit 15 (shifting the result right), and increment the counter.
REQ-017 The transition SHALL be SHIFT->DONE on the edge where the counter equals 15 (16th shift); the counter SHALL wrap to 0 on that edge.
REQ-018 Latency: with accept at edge k, out_valid SHALL be high from edge k+16 onward.
REQ-019 In DONE, out and out_valid SHALL hold stable until an edge with out_ready=1, after which the state SHALL be IDLE.
REQ-020 in_ready SHALL NOT assert in the same cycle as out_valid; back-to-back throughput SHALL be one word per 18 cycles when out_ready is held high.
REQ-021 in_valid, a and b SHALL be ignored outside IDLE; out_ready SHALL be ignored outside DONE.
REQ-022 out SHALL show the result register in all states; its value SHALL be defined (meaningful) only while out_valid=1.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE, counter 0, operand and result registers 0, out=16'h0000, out_valid=0, busy=0, in_ready=1 after that edge.
REQ-024 Reset SHALL take priority over all other inputs, including mid-SHIFT and in DONE; an aborted operation SHALL produce no out_valid.

Configuration
REQ-025 Macro SERIAL_AND16_NAND_EN, when defined, SHALL add input nand_sel (1 bit), sampled at accept; with nand_sel=1 each result bit SHALL be NOT(a[i] AND b[i]), and with nand_sel=0 it SHALL be AND.
REQ-026 Without SERIAL_AND16_NAND_EN, the nand_sel port SHALL be absent and the block SHALL compute AND only; all timing SHALL be identical in both builds.

Verification
REQ-027 Reset, then a=16'hFFFF, b=16'h0F0F, in_valid pulse, out_ready=1 -> out_valid high exactly 16 edges after accept, out=16'h0F0F, in_ready high the cycle after handoff.
REQ-028 a=16'hAAAA, b=16'h5555 -> out=16'h0000; then a=16'h8001, b=16'hFFFF -> out=16'h8001 (checks bit ordering at both ends).
REQ-029 Hold out_ready=0 for 5 cycles in DONE with a/b/in_valid toggling -> out and out_valid stable, in_ready=0, no new accept.
REQ-030 Assert reset after 7 SHIFT edges -> next cycle IDLE, out=16'h0000, out_valid=0, busy=0; next operation a=16'h1234, b=16'hFF00 -> out=16'h1200.
REQ-031 in_valid and out_ready held high continuously with 3 queued pairs -> accepts spaced 18 cycles apart, all results correct.
REQ-032 With SERIAL_AND16_NAND_EN, a=16'hFFFF, b=16'h00FF, nand_sel=1 -> out=16'hFF00; nand_sel=0 -> out=16'h00FF.
